// File: rtl/sparse_pkg.sv
// sparse_pkg: shared sizes, FSM states and lane helper for the sparse vector decoder.
package sparse_pkg;
  localparam int N = 8;
  localparam int DW = 9;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  function automatic logic [N*DW-1:0] lane_put(input logic [N*DW-1:0] v, input logic [PW-1:0] i,
                                               input logic [DW-1:0] d);
    logic [N*DW-1:0] r;
    r = v;
    r[i*DW +: DW] = d;
    return r;
  endfunction
endpackage

// File: rtl/lsb_find.sv
// lsb_find: index of the lowest set bit of a map, plus an any-bit-set flag.
module lsb_find #(
  parameter int N = 8
) (
  input  logic [N-1:0]         map_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);
  always_comb begin
    idx_o = '0;
    for (int j = N - 1; j >= 0; j--) idx_o = map_i[j] ? IW'(j) : idx_o;
    any_o = |map_i;
  end
endmodule

// File: rtl/sparse_decoder8.sv
// sparse_decoder8: expands a bitmap header plus packed non-zero elements into a dense vector.
module sparse_decoder8
  import sparse_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            hdr_valid,
  output logic            hdr_ready,
  input  logic [N-1:0]    hdr_map,
  input  logic            elem_valid,
  output logic            elem_ready,
  input  logic [DW-1:0]   elem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] dense_out,
  output logic [N-1:0]    out_map,
  output logic            zero_err
);
  state_t          state_q, state_d;
  logic [N-1:0]    map_q, map_d, work_q, work_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [N*DW-1:0] dense_q, dense_d;
  logic            zero_q, zero_d;
  logic [PW-1:0]   pos;
  logic            any;

  lsb_find #(.N(N)) u_lsb (.map_i(work_q), .idx_o(pos), .any_o(any));

  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    work_d     = work_q;
    rem_d      = rem_q;
    dense_d    = dense_q;
    zero_d     = 1'b0;
    hdr_ready  = state_q == IDLE;
    elem_ready = state_q == LOAD && any;
    out_valid  = state_q == DONE;
    if (hdr_valid && hdr_ready) begin
      map_d   = hdr_map;
      work_d  = hdr_map;
      dense_d = '0;
      rem_d   = CW'($countones(hdr_map));
      state_d = hdr_map == '0 ? DONE : LOAD;
    end
    if (elem_valid && elem_ready) begin
      dense_d = lane_put(dense_q, pos, elem_data);
      work_d  = work_q & ~(N'(1) << pos);
      rem_d   = rem_q - CW'(1);
      zero_d  = elem_data == '0;
      state_d = rem_q == CW'(1) ? DONE : LOAD;
    end
    if (out_valid && out_ready) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      map_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      dense_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dense_q <= dense_d;
      zero_q  <= zero_d;
    end
  end

  assign dense_out = dense_q;
  assign out_map   = map_q;
  assign zero_err  = zero_q;
endmodule

// File: tb/tb_sparse_decoder8.sv
// tb_sparse_decoder8: directed vectors with hand-computed dense results for sparse_decoder8.
module tb_sparse_decoder8;
  logic        clk = 1'b0, reset = 1'b1;
  logic        hdr_valid = 1'b0, hdr_ready;
  logic [7:0]  hdr_map = '0;
  logic        elem_valid = 1'b0, elem_ready;
  logic [8:0]  elem_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [71:0] dense_out;
  logic [7:0]  out_map;
  logic        zero_err;
  int n_vec = 0, n_err = 0, cyc = 0, t_acc = 0, zcnt = 0, lat, z0;
  logic [71:0] snap;

  sparse_decoder8 dut (
    .clk(clk), .reset(reset), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_map(hdr_map),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .out_valid(out_valid), .out_ready(out_ready), .dense_out(dense_out), .out_map(out_map),
    .zero_err(zero_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (zero_err) zcnt <= zcnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mk(input int l[8]);
    logic [71:0] r;
    for (int i = 0; i < 8; i++) r[i*9 +: 9] = 9'(l[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] m);
    int k = 0;
    hdr_valid = 1'b1;
    hdr_map = m;
    while (!hdr_ready && k < 50) begin tick(); k++; end
    if (!hdr_ready) chk("hdr_tmo", 0, 1);
    tick();
    hdr_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic send_elems(input int n, input int v[8], input bit gap);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      elem_valid = 1'b1;
      elem_data = 9'(v[i]);
      while (!elem_ready && k < 50) begin tick(); k++; end
      if (!elem_ready) chk("elem_tmo", 0, 1);
      tick();
      elem_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_out(output int l);
    int k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    if (!out_valid) chk("out_tmo", 0, 1);
    l = cyc - t_acc + 1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_hdr_ready", hdr_ready, 1);
    chk("rst_elem_ready", elem_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dense", dense_out, 0);
    chk("rst_map", out_map, 0);
    chk("rst_zero_err", zero_err, 0);
    reset = 1'b0;
    tick();
    chk("idle_hdr_ready", hdr_ready, 1);

    send_hdr(8'b1010_0101);
    send_elems(4, '{5, -3, 7, -256, 0, 0, 0, 0}, 1'b0);
    wait_out(lat);
    chk("sparse_lat", lat, 5);
    chk("sparse_dense", dense_out, mk('{5, 0, -3, 0, 0, 7, 0, -256}));
    chk("sparse_lane7", dense_out[71:63], 9'h100);
    chk("sparse_map", out_map, 8'hA5);
    chk("done_hdr_ready", hdr_ready, 0);
    chk("done_elem_ready", elem_ready, 0);
    drain();
    chk("drain_out_valid", out_valid, 0);

    send_hdr(8'h00);
    chk("empty_elem_ready", elem_ready, 0);
    wait_out(lat);
    chk("empty_lat", lat, 1);
    chk("empty_dense", dense_out, 0);
    drain();

    send_hdr(8'hFF);
    send_elems(8, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1);
    wait_out(lat);
    chk("full_dense", dense_out, mk('{1, 2, 3, 4, 5, 6, 7, 8}));
    chk("full_map", out_map, 8'hFF);

    snap = dense_out;
    hdr_map = 8'h02;
    hdr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hdr_ready", hdr_ready, 0);
      chk("bp_dense", dense_out, snap);
    end
    drain();
    chk("bp_idle_hdr_ready", hdr_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    tick();
    hdr_valid = 1'b0;
    t_acc = cyc;
    chk("bp_hdr_taken", elem_ready, 1);
    send_elems(1, '{12, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    wait_out(lat);
    chk("bp_lat", lat, 2);
    chk("bp_dense2", dense_out, mk('{0, 12, 0, 0, 0, 0, 0, 0}));
    drain();

    send_hdr(8'h0F);
    send_elems(2, '{5, 6, 0, 0, 0, 0, 0, 0}, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_dense", dense_out, 0);
    chk("mid_rst_elem_ready", elem_ready, 0);
    chk("mid_rst_hdr_ready", hdr_ready, 1);
    send_hdr(8'h01);
    send_elems(1, '{9, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    wait_out(lat);
    chk("after_rst_dense", dense_out, mk('{9, 0, 0, 0, 0, 0, 0, 0}));
    drain();

    chk("no_zero_err_yet", zcnt, 0);
    z0 = zcnt;
    send_hdr(8'h03);
    send_elems(2, '{0, 4, 0, 0, 0, 0, 0, 0}, 1'b0);
    wait_out(lat);
    tick();
    chk("zero_err_pulses", zcnt - z0, 1);
    chk("zero_dense", dense_out, mk('{0, 4, 0, 0, 0, 0, 0, 0}));
    chk("zero_lat", lat, 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
